// File: rtl/pe_pkg.sv
// Shared types, packet field layout and packet builder for the SNN processing element.
package pe_pkg;

  typedef enum logic [1:0] {
    IFMAP  = 2'b00,
    KERNEL = 2'b01,
    PSUM   = 2'b10,
    RSVD   = 2'b11
  } pkt_type_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FILT,
    COMPUTE,
    EMIT,
    FWD
  } state_e;

  localparam int PKT_LEN   = 34;
  localparam int ADDR_W    = 4;
  localparam int SRC_LSB   = 30;
  localparam int DST_LSB   = 26;
  localparam int TYPE_LSB  = 24;
  localparam int PAYLOAD_W = 24;

  // Assemble a NoC packet from its fields.
  function automatic logic [PKT_LEN-1:0] pack_pkt(input logic [ADDR_W-1:0]    src,
                                                  input logic [ADDR_W-1:0]    dst,
                                                  input pkt_type_e            ptype,
                                                  input logic [PAYLOAD_W-1:0] payload);
    return {src, dst, ptype, payload};
  endfunction

endpackage

// File: rtl/pe_mac8.sv
// Gated accumulator: adds the weight when the spike gate is set, wraps modulo 2^W_W.
module pe_mac8
  import pe_pkg::*;
#(
  parameter int W_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           gate,
  input  logic [W_W-1:0] w,
  output logic [W_W-1:0] sum
);

  logic [W_W-1:0] acc_q;
  logic [W_W-1:0] acc_d;

  // The accumulated value including the current tap, visible before the edge.
  always_comb begin
    sum = acc_q + (gate ? w : '0);
  end

  // Clear has priority over accumulate; otherwise hold.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pe_conv_sequencer.sv
// Control core of one SNN PE: takes kernel/ifmap packets, runs a 3-tap x 3-column
// spike convolution through pe_mac8, emits partial sums and optionally forwards the ifmap.
module pe_conv_sequencer
  import pe_pkg::*;
#(
  parameter int         PKT_W         = 34,
  parameter int         W_W           = 8,
  parameter int         IFMAP_W       = 5,
  parameter logic [3:0] MY_ADDR       = 4'b0110,
  parameter logic [3:0] ADDER_ADDR0   = 4'b0001,
  parameter logic [3:0] ADDER_ADDR1   = 4'b0101,
  parameter logic [3:0] ADDER_ADDR2   = 4'b1001,
  parameter logic [3:0] NEIGHBOR_ADDR = 4'b0010,
  parameter bit         NEIGHBOR_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PKT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             drop_pulse
);

  state_e               state_q, state_d;
  logic                 filter_vld_q, filter_vld_d;
  logic [W_W-1:0]       w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [IFMAP_W-1:0]   s_q, s_d;
  logic [1:0]           ifmap_cnt_q, ifmap_cnt_d;
  logic                 fwd_flag_q, fwd_flag_d;
  logic [1:0]           j_q, j_d, i_q, i_d;
  logic                 out_valid_q, out_valid_d;
  logic [PKT_W-1:0]     out_data_q, out_data_d;
  logic                 drop_pulse_q, drop_pulse_d;

  logic [ADDR_W-1:0]    in_dst;
  pkt_type_e            in_type;
  logic                 in_mine, in_drop, is_kernel, is_ifmap, in_xfer;
  logic                 unused_src;
  logic [1:0]           cnt_inc;
  logic [2:0]           tap_idx;
  logic                 mac_clr, mac_en, mac_gate;
  logic [W_W-1:0]       mac_w, acc_sum;
  logic [ADDR_W-1:0]    adder_addr;

  assign in_dst     = in_data[DST_LSB +: ADDR_W];
  assign in_type    = pkt_type_e'(in_data[TYPE_LSB +: 2]);
  assign unused_src = ^in_data[SRC_LSB +: ADDR_W];
  assign in_mine    = (in_dst == MY_ADDR);
  assign in_drop    = !in_mine || (in_type == PSUM) || (in_type == RSVD);
  assign is_kernel  = in_mine && (in_type == KERNEL);
  assign is_ifmap   = in_mine && (in_type == IFMAP);
  assign in_xfer    = in_valid && in_ready;
  assign cnt_inc    = (ifmap_cnt_q == 2'd3) ? 2'd1 : ifmap_cnt_q + 2'd1;

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign drop_pulse = drop_pulse_q;
  assign busy       = (state_q != IDLE);

  // Input handshake: an ifmap waiting for weights stalls further ifmaps only.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:      in_ready = 1'b1;
        WAIT_FILT: in_ready = in_valid && !is_ifmap;
        default:   in_ready = 1'b0;
      endcase
    end
  end

  // Select the spike bit and weight for the current tap and the column's adder address.
  always_comb begin
    tap_idx  = {1'b0, j_q} + {1'b0, i_q};
    mac_gate = s_q[tap_idx];
    case (i_q)
      2'd0:    mac_w = w0_q;
      2'd1:    mac_w = w1_q;
      default: mac_w = w2_q;
    endcase
    case (j_q)
      2'd0:    adder_addr = ADDER_ADDR0;
      2'd1:    adder_addr = ADDER_ADDR1;
      default: adder_addr = ADDER_ADDR2;
    endcase
  end

  // Accumulator control: clear whenever a new column starts, accumulate while computing.
  always_comb begin
    mac_clr = 1'b0;
    mac_en  = (state_q == COMPUTE);
    case (state_q)
      IDLE:      mac_clr = in_xfer && is_ifmap;
      WAIT_FILT: mac_clr = in_xfer && is_kernel;
      EMIT:      mac_clr = out_ready && (j_q != 2'd2);
      default:   mac_clr = 1'b0;
    endcase
  end

  pe_mac8 #(.W_W(W_W)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .gate (mac_gate),
    .w    (mac_w),
    .sum  (acc_sum)
  );

  // Sequencer next-state: packet intake, tap/column stepping and output packet build.
  always_comb begin
    state_d      = state_q;
    filter_vld_d = filter_vld_q;
    w0_d         = w0_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    s_d          = s_q;
    ifmap_cnt_d  = ifmap_cnt_q;
    fwd_flag_d   = fwd_flag_q;
    j_d          = j_q;
    i_d          = i_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    drop_pulse_d = in_xfer && in_drop;
    case (state_q)
      IDLE: begin
        if (in_xfer && is_kernel) begin
          w0_d         = in_data[0 +: W_W];
          w1_d         = in_data[W_W +: W_W];
          w2_d         = in_data[2*W_W +: W_W];
          filter_vld_d = 1'b1;
        end else if (in_xfer && is_ifmap) begin
          s_d         = in_data[0 +: IFMAP_W];
          ifmap_cnt_d = cnt_inc;
          fwd_flag_d  = NEIGHBOR_EN && (cnt_inc >= 2'd2);
          j_d         = 2'd0;
          i_d         = 2'd0;
          state_d     = filter_vld_q ? COMPUTE : WAIT_FILT;
        end
      end
      WAIT_FILT: begin
        if (in_xfer && is_kernel) begin
          w0_d         = in_data[0 +: W_W];
          w1_d         = in_data[W_W +: W_W];
          w2_d         = in_data[2*W_W +: W_W];
          filter_vld_d = 1'b1;
          j_d          = 2'd0;
          i_d          = 2'd0;
          state_d      = COMPUTE;
        end
      end
      COMPUTE: begin
        if (i_q == 2'd2) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_data_d  = pack_pkt(MY_ADDR, adder_addr, PSUM,
                                 {{(PAYLOAD_W-W_W){1'b0}}, acc_sum});
        end else begin
          i_d = i_q + 2'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (j_q != 2'd2) begin
            j_d         = j_q + 2'd1;
            i_d         = 2'd0;
            out_valid_d = 1'b0;
            state_d     = COMPUTE;
          end else if (fwd_flag_q) begin
            out_data_d  = pack_pkt(MY_ADDR, NEIGHBOR_ADDR, IFMAP,
                                   {{(PAYLOAD_W-IFMAP_W){1'b0}}, s_q});
            state_d     = FWD;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      FWD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Register all sequencer state and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      filter_vld_q <= 1'b0;
      w0_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      s_q          <= '0;
      ifmap_cnt_q  <= 2'd0;
      fwd_flag_q   <= 1'b0;
      j_q          <= 2'd0;
      i_q          <= 2'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      filter_vld_q <= filter_vld_d;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      s_q          <= s_d;
      ifmap_cnt_q  <= ifmap_cnt_d;
      fwd_flag_q   <= fwd_flag_d;
      j_q          <= j_d;
      i_q          <= i_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Self-checking bench for pe_conv_sequencer: a behavioural model pushes expected
// packets to a queue as stimulus is accepted; a monitor pops them on each output transfer.
module tb_pe_conv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        drop_pulse;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [33:0] expQ[$];

  logic [7:0]  mW0, mW1, mW2;
  bit          mFiltVld;
  int          mIfmapCnt;
  bit          mPending;
  logic [4:0]  mPendS;

  pe_conv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .drop_pulse (drop_pulse)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [33:0] observed, input logic [33:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] adderAddr(input int col);
    case (col)
      0:       return 4'b0001;
      1:       return 4'b0101;
      default: return 4'b1001;
    endcase
  endfunction

  // Expected partial sums (plus forwarded row) for one ifmap under the current weights.
  task automatic pushExpected(input logic [4:0] s);
    logic [7:0] psum;
    for (int col = 0; col < 3; col++) begin
      psum = (s[col] ? mW0 : 8'd0) + (s[col+1] ? mW1 : 8'd0) + (s[col+2] ? mW2 : 8'd0);
      expQ.push_back({4'b0110, adderAddr(col), 2'b10, 16'h0000, psum});
    end
    if (mIfmapCnt == 2 || mIfmapCnt == 3)
      expQ.push_back({4'b0110, 4'b0010, 2'b00, 19'h0, s});
  endtask

  task automatic modelAccept(input logic [33:0] pkt);
    if (pkt[29:26] == 4'b0110 && pkt[25:24] == 2'b01) begin
      mW0 = pkt[7:0];
      mW1 = pkt[15:8];
      mW2 = pkt[23:16];
      mFiltVld = 1'b1;
      if (mPending) begin
        mPending = 1'b0;
        pushExpected(mPendS);
      end
    end else if (pkt[29:26] == 4'b0110 && pkt[25:24] == 2'b00) begin
      mIfmapCnt = (mIfmapCnt == 3) ? 1 : mIfmapCnt + 1;
      if (mFiltVld) pushExpected(pkt[4:0]);
      else begin
        mPending = 1'b1;
        mPendS   = pkt[4:0];
      end
    end
  endtask

  task automatic modelReset();
    mW0 = 8'd0; mW1 = 8'd0; mW2 = 8'd0;
    mFiltVld = 1'b0; mIfmapCnt = 0; mPending = 1'b0; mPendS = 5'd0;
    expQ.delete();
  endtask

  // Offer one packet for up to maxWait cycles; called just after a rising edge.
  task automatic applyStimulus(input logic [33:0] pkt, input int maxWait, output bit accepted);
    bit ready;
    accepted = 1'b0;
    in_data  = pkt;
    in_valid = 1'b1;
    for (int k = 0; k < maxWait && !accepted; k++) begin
      @(negedge clk);
      ready = in_ready;
      @(posedge clk);
      #1;
      if (ready) accepted = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic sendPkt(input string tag, input logic [33:0] pkt, input bit expectAccept);
    bit acc;
    applyStimulus(pkt, expectAccept ? 20 : 4, acc);
    checkOutput({tag, "_accept"}, {33'd0, acc}, {33'd0, expectAccept});
    if (acc) modelAccept(pkt);
  endtask

  // Count falling edges until busy drops; an expired budget is a failure.
  task automatic waitIdle(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (!busy) return;
    end
    checkOutput("idleTimeout", {33'd0, busy}, 34'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [33:0] kernelPkt(input logic [23:0] w);
    return {4'b0000, 4'b0110, 2'b01, w};
  endfunction

  function automatic logic [33:0] ifmapPkt(input logic [4:0] s);
    return {4'b0000, 4'b0110, 2'b00, 19'h0, s};
  endfunction

  // Scoreboard monitor: every output transfer must match the oldest expected packet.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) checkOutput("unexpectedOut", 34'(expQ.size()), 34'd1);
      else checkOutput("outPkt", out_data, expQ.pop_front());
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and randomised test sequence.
  initial begin
    int n;
    logic [33:0] held;
    in_data   = 34'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    modelReset();
    in_valid  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", {33'd0, in_ready}, 34'd0);
    checkOutput("rstOutValid", {33'd0, out_valid}, 34'd0);
    checkOutput("rstOutData", out_data, 34'd0);
    checkOutput("rstBusy", {33'd0, busy}, 34'd0);
    checkOutput("rstDrop", {33'd0, drop_pulse}, 34'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic convolution and latency");
    sendPkt("t1Kernel", kernelPkt(24'h030201), 1'b1);
    sendPkt("t1Ifmap", ifmapPkt(5'b10110), 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t1EarlyValid", {33'd0, out_valid}, 34'd0);
    end
    @(negedge clk);
    checkOutput("t1Psum0Valid", {33'd0, out_valid}, 34'd1);
    checkOutput("t1Psum0Data", out_data, {4'b0110, 4'b0001, 2'b10, 16'h0, 8'd5});
    waitIdle(n);
    checkOutput("t1IdleCycle", 34'(n + 4), 34'd13);
    checkOutput("t1QueueEmpty", 34'(expQ.size()), 34'd0);

    $display("[TB] saturating weights wrap");
    @(posedge clk); #1;
    sendPkt("t2Kernel", kernelPkt(24'hFFFFFF), 1'b1);
    sendPkt("t2Ifmap", ifmapPkt(5'b11111), 1'b1);
    waitIdle(n);

    $display("[TB] ifmap before kernel");
    doReset();
    sendPkt("t3Ifmap", ifmapPkt(5'b00111), 1'b1);
    @(negedge clk);
    checkOutput("t3WaitBusy", {33'd0, busy}, 34'd1);
    @(posedge clk); #1;
    sendPkt("t3Stalled", ifmapPkt(5'b11000), 1'b0);
    sendPkt("t3DropRsvd", {4'b0000, 4'b0110, 2'b11, 24'h0}, 1'b1);
    @(negedge clk);
    checkOutput("t3DropPulse", {33'd0, drop_pulse}, 34'd1);
    @(posedge clk); #1;
    sendPkt("t3Kernel", kernelPkt(24'h010101), 1'b1);
    waitIdle(n);

    $display("[TB] forwarding after ifmaps 2 and 3");
    doReset();
    sendPkt("t4Kernel", kernelPkt(24'($urandom)), 1'b1);
    for (int k = 0; k < 4; k++) begin
      sendPkt("t4Ifmap", ifmapPkt(5'($urandom)), 1'b1);
      waitIdle(n);
      @(posedge clk); #1;
    end
    checkOutput("t4QueueEmpty", 34'(expQ.size()), 34'd0);

    $display("[TB] back-pressure during EMIT");
    out_ready = 1'b0;
    sendPkt("t5Ifmap", ifmapPkt(5'b01011), 1'b1);
    in_data  = kernelPkt(24'h0A0B0C);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    checkOutput("t5ValidSeen", {33'd0, out_valid}, 34'd1);
    held = out_data;
    if (expQ.size() > 0) checkOutput("t5FrontData", out_data, expQ[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t5HoldValid", {33'd0, out_valid}, 34'd1);
      checkOutput("t5HoldData", out_data, held);
      checkOutput("t5InReady", {33'd0, in_ready}, 34'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitIdle(n);

    $display("[TB] dropped packets");
    @(posedge clk); #1;
    sendPkt("t6DropDst", {4'b0000, 4'b1010, 2'b01, 24'hFFFFFF}, 1'b1);
    @(negedge clk);
    checkOutput("t6DropPulseA", {33'd0, drop_pulse}, 34'd1);
    checkOutput("t6BusyA", {33'd0, busy}, 34'd0);
    @(negedge clk);
    checkOutput("t6DropPulseEnd", {33'd0, drop_pulse}, 34'd0);
    @(posedge clk); #1;
    sendPkt("t6DropType", {4'b0000, 4'b0110, 2'b11, 24'h123456}, 1'b1);
    @(negedge clk);
    checkOutput("t6DropPulseB", {33'd0, drop_pulse}, 34'd1);
    checkOutput("t6BusyB", {33'd0, busy}, 34'd0);
    @(posedge clk); #1;
    sendPkt("t6Ifmap", ifmapPkt(5'b10101), 1'b1);
    waitIdle(n);

    $display("[TB] reset during COMPUTE");
    @(posedge clk); #1;
    sendPkt("t7Ifmap", ifmapPkt(5'b11111), 1'b1);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("t7OutValid", {33'd0, out_valid}, 34'd0);
    checkOutput("t7Busy", {33'd0, busy}, 34'd0);
    checkOutput("t7OutData", out_data, 34'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sendPkt("t7IfmapNoFilt", ifmapPkt(5'b01110), 1'b1);
    repeat (15) @(negedge clk);
    checkOutput("t7WaitFilt", {33'd0, busy}, 34'd1);
    checkOutput("t7NoOutput", {33'd0, out_valid}, 34'd0);
    @(posedge clk); #1;
    sendPkt("t7Kernel", kernelPkt(24'h402010), 1'b1);
    waitIdle(n);
    repeat (2) @(negedge clk);
    checkOutput("finalQueueEmpty", 34'(expQ.size()), 34'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
